// File: rtl/instr_stream_driver_pkg.sv
// Shared encodings for the instruction stream driver: Processor operation codes
// and the driver FSM state type.
package instr_stream_driver_pkg;

  localparam logic [1:0] OP_NO_OP   = 2'b00;
  localparam logic [1:0] OP_RESET   = 2'b11;
  localparam logic [1:0] OP_EXECUTE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/instr_stream_driver_stream_fifo.sv
// Circular-buffer FIFO holding packed {check, expected, instruction} entries.
// The head entry is presented combinationally on rdata.
module instr_stream_driver_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_stream_driver.sv
// Drives a queued instruction stream into Processor (RESET, then EXECUTE per entry)
// and checks syscallOut on tagged entries, reporting pass/fail counts.
module instr_stream_driver
  import instr_stream_driver_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int CHECK_LATENCY = 1,
  parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   loadValid,
  output logic                   loadReady,
  input  logic [WORD_WIDTH-1:0]  loadInstruction,
  input  logic                   loadCheck,
  input  logic [WORD_WIDTH-1:0]  loadExpected,
  input  logic                   start,
  output logic [1:0]             operation,
  output logic [WORD_WIDTH-1:0]  nextInstruction,
  input  logic [WORD_WIDTH-1:0]  syscallOut,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] passCount,
  output logic [COUNT_WIDTH-1:0] failCount,
  output logic                   failed,
  output logic [COUNT_WIDTH-1:0] firstFailIndex
);

  localparam int ENTRY_W = 2 * WORD_WIDTH + 1;
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int LAT_W   = $clog2(CHECK_LATENCY + 1);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + COUNT_WIDTH'(1);
  endfunction

  state_t                  state_r;
  logic [1:0]              operation_r;
  logic [WORD_WIDTH-1:0]   next_instr_r;
  logic                    busy_r;
  logic                    done_r;
  logic [COUNT_WIDTH-1:0]  pass_count_r;
  logic [COUNT_WIDTH-1:0]  fail_count_r;
  logic                    failed_r;
  logic [COUNT_WIDTH-1:0]  first_fail_r;
  logic [COUNT_WIDTH-1:0]  entry_index_r;
  logic [COUNT_WIDTH-1:0]  cur_index_r;
  logic                    cur_check_r;
  logic [WORD_WIDTH-1:0]   cur_expected_r;
  logic [LAT_W-1:0]        wait_cnt_r;

  logic [ENTRY_W-1:0]      head_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [OCC_W-1:0]        fifo_count_s;
  logic                    push_s;
  logic                    sample_now_s;
  logic                    issue_now_s;
  logic                    finish_now_s;

  assign loadReady = ((state_r == ST_IDLE) || (state_r == ST_DONE))
                     && (fifo_count_s < OCC_W'(DEPTH));
  assign push_s       = loadValid && loadReady && !fifo_full_s;
  assign sample_now_s = (state_r == ST_WAIT) && (wait_cnt_r == LAT_W'(1));

  instr_stream_driver_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push_s),
    .pop   (issue_now_s),
    .wdata ({loadCheck, loadExpected, loadInstruction}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Decide whether the coming edge issues the head entry or ends the run.
  always_comb begin
    issue_now_s  = 1'b0;
    finish_now_s = 1'b0;
    case (state_r)
      ST_RST: begin
        issue_now_s  = !fifo_empty_s;
        finish_now_s = fifo_empty_s;
      end
      ST_ISSUE: begin
        if (cur_check_r) begin
          issue_now_s  = 1'b0;
          finish_now_s = 1'b0;
        end else begin
          issue_now_s  = !fifo_empty_s;
          finish_now_s = fifo_empty_s;
        end
      end
      ST_WAIT: begin
        issue_now_s  = sample_now_s && !fifo_empty_s;
        finish_now_s = sample_now_s && fifo_empty_s;
      end
      default: begin
        issue_now_s  = 1'b0;
        finish_now_s = 1'b0;
      end
    endcase
  end

  // Run-control FSM with registered Processor-facing and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      operation_r    <= OP_NO_OP;
      next_instr_r   <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_count_r   <= '0;
      fail_count_r   <= '0;
      failed_r       <= 1'b0;
      first_fail_r   <= '0;
      entry_index_r  <= '0;
      cur_index_r    <= '0;
      cur_check_r    <= 1'b0;
      cur_expected_r <= '0;
      wait_cnt_r     <= '0;
    end else begin
      if (sample_now_s) begin
        if (syscallOut == cur_expected_r) begin
          pass_count_r <= sat_inc(pass_count_r);
        end else begin
          fail_count_r <= sat_inc(fail_count_r);
          failed_r     <= 1'b1;
          if (fail_count_r == '0) begin
            first_fail_r <= cur_index_r;
          end
        end
      end

      if (issue_now_s) begin
        state_r        <= ST_ISSUE;
        operation_r    <= OP_EXECUTE;
        next_instr_r   <= head_s[WORD_WIDTH-1:0];
        cur_expected_r <= head_s[2*WORD_WIDTH-1:WORD_WIDTH];
        cur_check_r    <= head_s[ENTRY_W-1];
        cur_index_r    <= entry_index_r;
        entry_index_r  <= sat_inc(entry_index_r);
      end else if (finish_now_s) begin
        state_r     <= ST_DONE;
        operation_r <= OP_NO_OP;
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_r       <= ST_RST;
              operation_r   <= OP_RESET;
              busy_r        <= 1'b1;
              done_r        <= 1'b0;
              pass_count_r  <= '0;
              fail_count_r  <= '0;
              failed_r      <= 1'b0;
              first_fail_r  <= '0;
              entry_index_r <= '0;
            end
          end
          // Only a checked entry stays here without issuing or finishing.
          ST_ISSUE: begin
            state_r     <= ST_WAIT;
            operation_r <= OP_NO_OP;
            wait_cnt_r  <= LAT_W'(CHECK_LATENCY);
          end
          ST_WAIT: begin
            wait_cnt_r <= wait_cnt_r - LAT_W'(1);
          end
          default: begin
            state_r     <= ST_IDLE;
            operation_r <= OP_NO_OP;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign operation       = operation_r;
  assign nextInstruction = next_instr_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign passCount       = pass_count_r;
  assign failCount       = fail_count_r;
  assign failed          = failed_r;
  assign firstFailIndex  = first_fail_r;

endmodule

// File: tb/tb_instr_stream_driver.sv
// Scoreboard bench: two drivers (CHECK_LATENCY 1 and 2) share stimulus; a monitor
// summarises each run and compares it against hand-computed expected records.
module tb_instr_stream_driver;
  import instr_stream_driver_pkg::*;

  localparam int WW = 32;
  localparam int CW = 5;

  typedef struct packed {
    logic [31:0]   rst_c;
    logic [31:0]   exe_c;
    logic [31:0]   nop_c;
    logic [31:0]   busy_c;
    logic [31:0]   sum;
    logic          done;
    logic          failed;
    logic [CW-1:0] pc;
    logic [CW-1:0] fc;
    logic [CW-1:0] ffi;
  } run_t;

  typedef struct packed {
    logic [1:0]    op;
    logic          busy;
    logic          done;
    logic          ready;
    logic          failed;
    logic [CW-1:0] pc;
    logic [CW-1:0] fc;
    logic [CW-1:0] ffi;
  } snap_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic loadValid = 1'b0;
  logic loadCheck = 1'b0;
  logic start = 1'b0;
  logic [WW-1:0] loadInstruction = '0;
  logic [WW-1:0] loadExpected = '0;
  logic [WW-1:0] syscallOut = '0;

  logic          ready_w  [2];
  logic [1:0]    op_w     [2];
  logic [WW-1:0] ni_w     [2];
  logic          busy_w   [2];
  logic          done_w   [2];
  logic          failed_w [2];
  logic [CW-1:0] pc_w     [2];
  logic [CW-1:0] fc_w     [2];
  logic [CW-1:0] ffi_w    [2];

  run_t  q0[$];
  run_t  q1[$];
  snap_t sq[$];
  bit    finish_req = 1'b0;
  int    checks = 0;
  int    failures = 0;
  logic [31:0] run_sum = '0;

  always #5 clock = ~clock;

  instr_stream_driver #(.WORD_WIDTH(WW), .DEPTH(16), .CHECK_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset), .loadValid(loadValid), .loadReady(ready_w[0]),
    .loadInstruction(loadInstruction), .loadCheck(loadCheck), .loadExpected(loadExpected),
    .start(start), .operation(op_w[0]), .nextInstruction(ni_w[0]), .syscallOut(syscallOut),
    .busy(busy_w[0]), .done(done_w[0]), .passCount(pc_w[0]), .failCount(fc_w[0]),
    .failed(failed_w[0]), .firstFailIndex(ffi_w[0])
  );

  instr_stream_driver #(.WORD_WIDTH(WW), .DEPTH(16), .CHECK_LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .loadValid(loadValid), .loadReady(ready_w[1]),
    .loadInstruction(loadInstruction), .loadCheck(loadCheck), .loadExpected(loadExpected),
    .start(start), .operation(op_w[1]), .nextInstruction(ni_w[1]), .syscallOut(syscallOut),
    .busy(busy_w[1]), .done(done_w[1]), .passCount(pc_w[1]), .failCount(fc_w[1]),
    .failed(failed_w[1]), .firstFailIndex(ffi_w[1])
  );

  function automatic run_t mk(input int r, input int e, input int n, input int b,
                              input logic d, input logic f, input logic [CW-1:0] pc,
                              input logic [CW-1:0] fc, input logic [CW-1:0] ffi,
                              input logic [31:0] s);
    run_t t;
    t.rst_c = 32'(r); t.exe_c = 32'(e); t.nop_c = 32'(n); t.busy_c = 32'(b);
    t.sum = s; t.done = d; t.failed = f; t.pc = pc; t.fc = fc; t.ffi = ffi;
    return t;
  endfunction

  function automatic snap_t mks(input logic [1:0] op, input logic b, input logic d,
                                input logic r, input logic f, input logic [CW-1:0] pc,
                                input logic [CW-1:0] fc, input logic [CW-1:0] ffi);
    snap_t t;
    t.op = op; t.busy = b; t.done = d; t.ready = r; t.failed = f;
    t.pc = pc; t.fc = fc; t.ffi = ffi;
    return t;
  endfunction

  // Monitor / scoreboard: compares snapshots of dut0 and whole-run summaries of both DUTs.
  initial begin
    run_t  acc [2];
    logic  prev_busy [2];
    int    runs [2];
    run_t  got;
    run_t  exp;
    snap_t s_got;
    snap_t s_exp;
    bit    have;
    for (int k = 0; k < 2; k++) begin
      acc[k] = '0; prev_busy[k] = 1'b0; runs[k] = 0;
    end
    forever begin
      @(negedge clock);
      if (sq.size() > 0) begin
        s_exp = sq.pop_front();
        s_got = mks(op_w[0], busy_w[0], done_w[0], ready_w[0], failed_w[0],
                    pc_w[0], fc_w[0], ffi_w[0]);
        checks++;
        if (s_got !== s_exp) begin
          failures++;
          $display("FAIL snapshot t=%0t op/busy/done/ready/failed/pass/fail/ffi got %h/%b/%b/%b/%b/%0d/%0d/%0d required %h/%b/%b/%b/%b/%0d/%0d/%0d",
                   $time, s_got.op, s_got.busy, s_got.done, s_got.ready, s_got.failed, s_got.pc, s_got.fc, s_got.ffi,
                   s_exp.op, s_exp.busy, s_exp.done, s_exp.ready, s_exp.failed, s_exp.pc, s_exp.fc, s_exp.ffi);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (busy_w[k]) begin
          acc[k].busy_c = acc[k].busy_c + 32'd1;
          if (op_w[k] == OP_RESET)   acc[k].rst_c = acc[k].rst_c + 32'd1;
          if (op_w[k] == OP_NO_OP)   acc[k].nop_c = acc[k].nop_c + 32'd1;
          if (op_w[k] == OP_EXECUTE) begin
            acc[k].exe_c = acc[k].exe_c + 32'd1;
            acc[k].sum   = acc[k].sum + ni_w[k];
          end
        end
        if (prev_busy[k] && !busy_w[k]) begin
          got = acc[k];
          got.done = done_w[k]; got.failed = failed_w[k];
          got.pc = pc_w[k]; got.fc = fc_w[k]; got.ffi = ffi_w[k];
          have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
          exp = '0;
          if (have) exp = (k == 0) ? q0.pop_front() : q1.pop_front();
          checks++;
          if (!have || got !== exp) begin
            failures++;
            $display("FAIL run%0d dut%0d got rst=%0d exe=%0d nop=%0d busy=%0d sum=%h done=%b failed=%b pass=%0d fail=%0d ffi=%0d required rst=%0d exe=%0d nop=%0d busy=%0d sum=%h done=%b failed=%b pass=%0d fail=%0d ffi=%0d (expected record present=%0d)",
                     runs[k], k, got.rst_c, got.exe_c, got.nop_c, got.busy_c, got.sum, got.done, got.failed, got.pc, got.fc, got.ffi,
                     exp.rst_c, exp.exe_c, exp.nop_c, exp.busy_c, exp.sum, exp.done, exp.failed, exp.pc, exp.fc, exp.ffi, have);
          end
          runs[k]++;
          acc[k] = '0;
        end
        prev_busy[k] = busy_w[k];
      end
      if (finish_req) begin
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || sq.size() != 0) begin
          failures++;
          $display("FAIL leftover_expectations got q0=%0d q1=%0d snaps=%0d required 0/0/0",
                   q0.size(), q1.size(), sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [WW-1:0] ins, input logic chk, input logic [WW-1:0] expv);
    bit taken;
    int n;
    taken = 1'b0;
    n = 0;
    loadValid = 1'b1; loadInstruction = ins; loadCheck = chk; loadExpected = expv;
    while (!taken && n < 50) begin
      taken = ready_w[0] && ready_w[1];
      cycle();
      n++;
    end
    if (taken) run_sum = run_sum + ins;
    loadValid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 200) begin
      cycle();
      n++;
    end
  endtask

  // Directed stimulus; expectations are queued before each run begins.
  initial begin
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0));
    cycle();

    // li r8,-5512513 (lui+ori) then syscall checked against 0xFFABE2BF; last load rides with start
    run_sum = '0;
    syscallOut = 32'hFFABE2BF;
    load(32'h3C08FFAB, 1'b0, 32'h0);
    load(32'h3508E2BF, 1'b0, 32'h0);
    run_sum = run_sum + 32'h0000000C;
    q0.push_back(mk(1, 3, 1, 5, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, run_sum));
    q1.push_back(mk(1, 3, 2, 6, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, run_sum));
    loadValid = 1'b1; loadInstruction = 32'h0000000C; loadCheck = 1'b1;
    loadExpected = 32'hFFABE2BF; start = 1'b1;
    cycle();
    loadValid = 1'b0; start = 1'b0;
    wait_idle();
    cycle();
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0));
    cycle();

    // middle entry expects 16 but processor returns 0
    run_sum = '0;
    syscallOut = 32'h0;
    load(32'h24080001, 1'b0, 32'h0);
    load(32'h0000000C, 1'b1, 32'd16);
    load(32'h24090002, 1'b0, 32'h0);
    q0.push_back(mk(1, 3, 1, 5, 1'b1, 1'b1, 5'd0, 5'd1, 5'd1, run_sum));
    q1.push_back(mk(1, 3, 2, 6, 1'b1, 1'b1, 5'd0, 5'd1, 5'd1, run_sum));
    pulse_start();
    wait_idle();
    cycle();
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 5'd1));
    cycle();

    // fill all 16 entries; a 17th offer is refused
    run_sum = '0;
    for (int i = 0; i < 16; i++) load(32'h10000000 + 32'(i), 1'b0, 32'h0);
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 5'd1));
    loadValid = 1'b1; loadInstruction = 32'hDEADBEEF; loadCheck = 1'b0;
    cycle();
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 5'd1));
    cycle();
    loadValid = 1'b0;
    q0.push_back(mk(1, 16, 0, 17, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, run_sum));
    q1.push_back(mk(1, 16, 0, 17, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, run_sum));
    pulse_start();
    wait_idle();
    cycle();

    // empty queue: one RESET cycle then DONE
    q0.push_back(mk(1, 0, 0, 1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    q1.push_back(mk(1, 0, 0, 1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    pulse_start();
    wait_idle();
    cycle();

    // reset after two of five entries have been issued
    for (int i = 1; i <= 5; i++) load(32'h20000000 + 32'(i), 1'b0, 32'h0);
    q0.push_back(mk(1, 2, 0, 3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h40000003));
    q1.push_back(mk(1, 2, 0, 3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h40000003));
    pulse_start();
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    sq.push_back(mks(OP_NO_OP, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0));
    cycle();
    reset = 1'b0;
    cycle();
    q0.push_back(mk(1, 0, 0, 1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    q1.push_back(mk(1, 0, 0, 1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    pulse_start();
    wait_idle();
    cycle();

    // start pulsed while both drivers sit in WAIT must be ignored
    run_sum = '0;
    syscallOut = 32'h12345678;
    load(32'h30000001, 1'b1, 32'h12345678);
    load(32'h30000002, 1'b1, 32'h00000000);
    load(32'h30000003, 1'b0, 32'h0);
    q0.push_back(mk(1, 3, 2, 6, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, run_sum));
    q1.push_back(mk(1, 3, 4, 8, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, run_sum));
    pulse_start();
    cycle();
    cycle();
    start = 1'b1;
    sq.push_back(mks(OP_NO_OP, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    cycle();
    start = 1'b0;
    wait_idle();
    cycle();
    cycle();

    finish_req = 1'b1;
  end

endmodule
